// File: rtl/hyperbus_phy2r.sv
// HyperBus read path: packs 16*NumPhys-bit PHY beats into AXI R beats honouring size, start address and length.
// Optional macro HYPERBUS_PHY2R_ZERO_LANES_EN drives lanes outside the active AXI beat to zero.
module hyperbus_phy2r #(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned NumPhys      = 2,
  parameter int unsigned BurstLength  = 8,
  parameter int unsigned AddrWidth    = $clog2(AxiDataWidth/8)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      trans_handshake_i,
  input  logic                      is_a_read_i,
  input  logic [2:0]                size_i,
  input  logic [AddrWidth-1:0]      start_addr_i,
  input  logic [BurstLength-1:0]    len_i,
  input  logic                      phy_valid_i,
  output logic                      phy_ready_o,
  input  logic [16*NumPhys-1:0]     phy_data_i,
  input  logic                      phy_last_i,
  input  logic                      phy_error_i,
  output logic                      axi_valid_o,
  input  logic                      axi_ready_i,
  output logic [AxiDataWidth-1:0]   axi_data_o,
  output logic                      axi_last_o,
  output logic                      axi_error_o,
  output logic [1:0]                state_o
);
  localparam int unsigned PhyBytes = 2 * NumPhys;
  localparam int unsigned AxiBytes = AxiDataWidth / 8;
  localparam logic [AddrWidth-1:0] PbMask = AddrWidth'(PhyBytes - 1);
  localparam logic [AddrWidth-1:0] PbStep = AddrWidth'(PhyBytes);

  typedef enum logic [1:0] {Idle = 2'd0, Fill = 2'd1, Send = 2'd2, Drain = 2'd3} state_e;

  // Handshakes: a PHY beat transfers when phy_valid_i & phy_ready_o at clk_i;
  // an R beat transfers when axi_valid_o & axi_ready_i. The two never coincide.
  state_e                       state_q, state_d;
  logic [AxiBytes-1:0][7:0]     buf_q;
  logic [AddrWidth-1:0]         ptr_q, beat_addr_q;
  logic [BurstLength-1:0]       beats_left_q;
  logic [2:0]                   size_q;
  logic                         err_q, last_seen_q;

  logic [AddrWidth-1:0] size_mask, beat_end, next_addr;
  logic                 phy_hs, axi_hs, beat_done;

  // beat_end is the last byte of the current AXI beat; the beat is complete once
  // the PHY window containing that byte is written.
  assign size_mask = AddrWidth'((32'd1 << size_q) - 32'd1);
  assign beat_end  = beat_addr_q | size_mask;
  assign next_addr = beat_end + AddrWidth'(1);
  assign beat_done = ((beat_end & ~PbMask) == ptr_q);
  assign phy_hs    = phy_valid_i & phy_ready_o;
  assign axi_hs    = axi_valid_o & axi_ready_i;
  assign state_o   = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= Idle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle:  if (trans_handshake_i && is_a_read_i) state_d = Fill;
      Fill:  if ((phy_hs && beat_done) || last_seen_q) state_d = Send;
      Send: begin
        if (axi_hs) begin
          if (beats_left_q == '0)               state_d = last_seen_q ? Idle : Drain;
          else if ((next_addr & PbMask) != '0)  state_d = Send;
          else                                  state_d = Fill;
        end
      end
      Drain: if (phy_hs && phy_last_i) state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    phy_ready_o = ((state_q == Fill) && !last_seen_q) || (state_q == Drain);
    axi_valid_o = (state_q == Send);
    axi_last_o  = (state_q == Send) && (beats_left_q == '0);
    axi_error_o = (state_q == Send) && err_q;
    axi_data_o  = buf_q;
`ifdef HYPERBUS_PHY2R_ZERO_LANES_EN
    for (int unsigned k = 0; k < AxiBytes; k++) begin
      if ((AddrWidth'(k) & ~size_mask) != (beat_addr_q & ~size_mask))
        axi_data_o[8*k +: 8] = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q        <= '0;
      ptr_q        <= '0;
      beat_addr_q  <= '0;
      beats_left_q <= '0;
      size_q       <= '0;
      err_q        <= 1'b0;
      last_seen_q  <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (trans_handshake_i && is_a_read_i) begin
            ptr_q        <= start_addr_i & ~PbMask;
            beat_addr_q  <= start_addr_i;
            beats_left_q <= len_i;
            size_q       <= size_i;
            err_q        <= 1'b0;
            last_seen_q  <= 1'b0;
          end
        end
        Fill: begin
          if (phy_hs) begin
            for (int unsigned i = 0; i < PhyBytes; i++)
              buf_q[ptr_q + AddrWidth'(i)] <= phy_data_i[8*i +: 8];
            ptr_q <= ptr_q + PbStep;
            err_q <= err_q | phy_error_i;
            if (phy_last_i) last_seen_q <= 1'b1;
          end else if (last_seen_q) begin
            // PHY ended early: remaining AXI beats go out flagged as errors.
            err_q <= 1'b1;
          end
        end
        Send: begin
          if (axi_hs) begin
            err_q       <= 1'b0;
            beat_addr_q <= next_addr;
            if (beats_left_q != '0) beats_left_q <= beats_left_q - 1'b1;
          end
        end
        Drain: begin
          if (phy_hs && phy_last_i) last_seen_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hyperbus_phy2r.sv
// Directed bench for hyperbus_phy2r: drives PHY beats and checks R beats against an expected queue.
module tb_hyperbus_phy2r;
  localparam int W = 74; // {lane mask[7:0], data[63:0], last, err}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trans = 1'b0, rd = 1'b0;
  logic [2:0]  size = '0;
  logic [2:0]  addr = '0;
  logic [7:0]  len = '0;
  logic        phy_valid = 1'b0, phy_last = 1'b0, phy_err = 1'b0;
  logic [31:0] phy_data = '0;
  logic        phy_ready;
  logic        axi_valid, axi_last, axi_error;
  logic        axi_ready = 1'b1;
  logic [63:0] axi_data;
  logic [1:0]  state;

  logic [W-1:0] exp_q[$];
  int           hs_cyc[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  hyperbus_phy2r dut (
    .clk_i(clk), .rst_i(rst),
    .trans_handshake_i(trans), .is_a_read_i(rd), .size_i(size),
    .start_addr_i(addr), .len_i(len),
    .phy_valid_i(phy_valid), .phy_ready_o(phy_ready), .phy_data_i(phy_data),
    .phy_last_i(phy_last), .phy_error_i(phy_err),
    .axi_valid_o(axi_valid), .axi_ready_i(axi_ready), .axi_data_o(axi_data),
    .axi_last_o(axi_last), .axi_error_o(axi_error), .state_o(state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] expand(input logic [7:0] m);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = {8{m[k]}};
    return r;
  endfunction

  // Scoreboard: each R handshake pops one expected beat.
  always @(negedge clk) begin
    if (!rst && axi_valid && axi_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_r_beat", 64'(axi_valid), 64'd0);
      end else begin
        logic [W-1:0] e;
        logic [63:0]  msk;
        e   = exp_q.pop_front();
        msk = expand(e[73:66]);
`ifdef HYPERBUS_PHY2R_ZERO_LANES_EN
        msk = '1;
`endif
        check("r_data", axi_data & msk, e[65:2] & msk);
        check("r_last", 64'(axi_last), 64'(e[1]));
        check("r_err",  64'(axi_error), 64'(e[0]));
      end
    end
  end

  // Driver tasks
  task automatic start_read(input logic [2:0] sz, input logic [2:0] a, input logic [7:0] l);
    trans = 1'b1; rd = 1'b1; size = sz; addr = a; len = l;
    @(posedge clk); #1;
    trans = 1'b0; rd = 1'b0;
  endtask

  task automatic phy_beat(input logic [31:0] d, input logic l, input logic e, input bit chk_valid);
    int n;
    n = 0;
    phy_valid = 1'b1; phy_data = d; phy_last = l; phy_err = e;
    do begin
      @(negedge clk);
      n++;
    end while (!phy_ready && n < 100);
    check("phy_accept_timeout", 64'(phy_ready), 64'd1);
    @(posedge clk); #1;
    phy_valid = 1'b0; phy_last = 1'b0; phy_err = 1'b0;
    if (chk_valid) check("valid_latency", 64'(axi_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || state != 2'd0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_state", 64'(state), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic push(input logic [7:0] m, input logic [63:0] d, input logic l, input logic e);
    exp_q.push_back({m, d, l, e});
  endtask

  task automatic run_basic(input int err_beat);
    start_read(3'd3, 3'd0, 8'd1);
    push(8'hFF, 64'h0706050403020100, 1'b0, 1'b0);
    push(8'hFF, 64'h0F0E0D0C0B0A0908, 1'b1, err_beat == 2);
    phy_beat(32'h03020100, 1'b0, err_beat == 0, 1'b0);
    phy_beat(32'h07060504, 1'b0, err_beat == 1, 1'b1);
    phy_beat(32'h0B0A0908, 1'b0, err_beat == 2, 1'b0);
    phy_beat(32'h0F0E0D0C, 1'b1, err_beat == 3, 1'b1);
    wait_idle();
  endtask

  initial begin
    int base;
    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_phy_ready", 64'(phy_ready), 64'd0);
    check("rst_axi_valid", 64'(axi_valid), 64'd0);
    check("rst_axi_last", 64'(axi_last), 64'd0);
    check("rst_axi_error", 64'(axi_error), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write handshake is ignored
    trans = 1'b1; rd = 1'b0;
    @(posedge clk); #1;
    trans = 1'b0;
    check("write_ignored", 64'(state), 64'd0);

    // 1: full-width two-beat burst
    run_basic(-1);

    // 2: narrow unaligned burst, two R beats from one PHY beat
    base = hs_cyc.size();
    start_read(3'd1, 3'd2, 8'd2);
    push(8'b0000_1100, 64'h0000_0000_3322_0000, 1'b0, 1'b0);
    push(8'b0011_0000, 64'h0000_5544_0000_0000, 1'b0, 1'b0);
    push(8'b1100_0000, 64'h7766_0000_0000_0000, 1'b1, 1'b0);
    phy_beat(32'h33221100, 1'b0, 1'b0, 1'b1);
    phy_beat(32'h77665544, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check("narrow_beat_count", 64'(hs_cyc.size() - base), 64'd3);
    if (hs_cyc.size() - base == 3)
      check("narrow_back_to_back", 64'(hs_cyc[base+2] - hs_cyc[base+1]), 64'd1);

    // 3: R stall for 5 cycles on beat 0 with a PHY beat pending
    axi_ready = 1'b0;
    start_read(3'd3, 3'd0, 8'd1);
    push(8'hFF, 64'h0706050403020100, 1'b0, 1'b0);
    push(8'hFF, 64'h0F0E0D0C0B0A0908, 1'b1, 1'b0);
    phy_beat(32'h03020100, 1'b0, 1'b0, 1'b0);
    phy_beat(32'h07060504, 1'b0, 1'b0, 1'b1);
    phy_valid = 1'b1; phy_data = 32'h0B0A0908;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 64'(axi_valid), 64'd1);
      check("stall_phy_ready", 64'(phy_ready), 64'd0);
      check("stall_data", axi_data, 64'h0706050403020100);
    end
    @(posedge clk); #1;
    axi_ready = 1'b1;
    phy_beat(32'h0B0A0908, 1'b0, 1'b0, 1'b0);
    phy_beat(32'h0F0E0D0C, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // 4: PHY error on beat 2 only
    run_basic(2);

    // 5a: early phy_last on PHY beat 2
    start_read(3'd3, 3'd0, 8'd1);
    push(8'hFF, 64'h0706050403020100, 1'b0, 1'b0);
    push(8'hFF, 64'h070605040B0A0908, 1'b1, 1'b1);
    phy_beat(32'h03020100, 1'b0, 1'b0, 1'b0);
    phy_beat(32'h07060504, 1'b0, 1'b0, 1'b1);
    phy_beat(32'h0B0A0908, 1'b1, 1'b0, 1'b0);
    wait_idle();

    // 5b: single byte beat, surplus PHY beat drained
    start_read(3'd0, 3'd0, 8'd0);
    push(8'h01, 64'h0000_0000_0000_00A0, 1'b1, 1'b0);
    phy_beat(32'hA3A2A1A0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("drain_state", 64'(state), 64'd3);
    phy_beat(32'hB3B2B1B0, 1'b1, 1'b0, 1'b0);
    wait_idle();

    // 6: reset while in Send, then a clean burst
    axi_ready = 1'b0;
    start_read(3'd3, 3'd0, 8'd1);
    phy_beat(32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    phy_beat(32'hCAFEF00D, 1'b0, 1'b1, 1'b1);
    check("pre_reset_send", 64'(state), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_state", 64'(state), 64'd0);
    check("mid_rst_valid", 64'(axi_valid), 64'd0);
    check("mid_rst_phy_ready", 64'(phy_ready), 64'd0);
    check("mid_rst_last", 64'(axi_last), 64'd0);
    check("mid_rst_error", 64'(axi_error), 64'd0);
    check("mid_rst_data", axi_data, 64'd0);
    rst = 1'b0;
    axi_ready = 1'b1;
    @(posedge clk); #1;
    run_basic(-1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
